falling_object_pool_move: RTL and testbench

//  Multi-slot successor to the single falling-object mover. Manages NUM_OBJ independent

---
 rtl/falling_obj_pkg.sv | 23 ++
 rtl/falling_obj_slot.sv | 92 +++++++++
 rtl/falling_object_pool_move.sv | 103 ++++++++++
 tb/tb_falling_object_pool_move.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/falling_obj_pkg.sv
// Shared types and helpers for the falling-object pool: fixed-point values, pixel
// coordinates and the per-slot state record.
package falling_obj_pkg;

  typedef logic signed [10:0] coord_t;
  typedef int signed          fp_t;

  localparam int FRAC_BITS_DEFAULT = 6;

  typedef struct packed {
    logic active;
    fp_t  x;
    fp_t  y;
    fp_t  vx;
    fp_t  vy;
  } slot_state_t;

  // Floor to whole pixels, then keep the low 11 bits.
  function automatic coord_t fp_to_px(input fp_t v, input int frac);
    return coord_t'(v >>> frac);
  endfunction

endpackage

// File: rtl/falling_obj_slot.sv
// One falling-object slot: position/velocity registers, gravity, side-wall bounce and
// exit detection at the bottom line.
module falling_obj_slot
  import falling_obj_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int OBJ_W     = 32,
  parameter int SPAWN_Y   = 0,
  parameter int GRAVITY   = 0,
  parameter int VY_MAX    = 512
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_update,
  input  logic              i_kill,
  input  logic              i_load,
  input  coord_t            i_spawn_x,
  input  logic signed [7:0] i_spawn_vx,
  input  logic        [7:0] i_spawn_vy,
  output logic              o_active,
  output logic              o_exceed,
  output coord_t            o_px_x,
  output coord_t            o_px_y
);

  localparam fp_t X_LIM  = (X_MAX - OBJ_W) <<< FRAC_BITS;
  localparam fp_t Y_EXIT = Y_MAX <<< FRAC_BITS;

  slot_state_t r_state;
  logic        r_exceed;

  fp_t  w_vy_sum;
  fp_t  w_vy_new;
  fp_t  w_y_new;
  fp_t  w_x_sum;
  fp_t  w_x_new;
  fp_t  w_vx_new;
  logic w_exit;

  always_comb begin
    w_vy_sum = r_state.vy + GRAVITY;
    w_vy_new = (w_vy_sum > VY_MAX) ? VY_MAX : w_vy_sum;
    w_y_new  = r_state.y + w_vy_new;
    w_x_sum  = r_state.x + r_state.vx;
    w_x_new  = w_x_sum;
    w_vx_new = r_state.vx;
    if (w_x_sum < 0) begin
      w_x_new  = 0;
      w_vx_new = -r_state.vx;
    end else if (w_x_sum > X_LIM) begin
      w_x_new  = X_LIM;
      w_vx_new = -r_state.vx;
    end
    w_exit = (w_y_new >= Y_EXIT);
  end

  // Kill beats motion; a load only ever targets an inactive slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= '0;
      r_exceed <= 1'b0;
    end else begin
      r_exceed <= 1'b0;
      if (r_state.active && i_kill) begin
        r_state.active <= 1'b0;
      end else if (r_state.active && i_update) begin
        r_state.x  <= w_x_new;
        r_state.y  <= w_y_new;
        r_state.vx <= w_vx_new;
        r_state.vy <= w_vy_new;
        if (w_exit) begin
          r_state.active <= 1'b0;
          r_exceed       <= 1'b1;
        end
      end else if (i_load) begin
        r_state.active <= 1'b1;
        r_state.x      <= fp_t'(i_spawn_x) <<< FRAC_BITS;
        r_state.y      <= SPAWN_Y <<< FRAC_BITS;
        r_state.vx     <= fp_t'(i_spawn_vx);
        r_state.vy     <= fp_t'(i_spawn_vy);
      end
    end
  end

  assign o_active = r_state.active;
  assign o_exceed = r_exceed;
  assign o_px_x   = fp_to_px(r_state.x, FRAC_BITS);
  assign o_px_y   = fp_to_px(r_state.y, FRAC_BITS);

endmodule

// File: rtl/falling_object_pool_move.sv
// Pool of NUM_OBJ falling objects: lowest-free-slot allocation with a registered spawn
// handshake, plus per-slot motion instances.
module falling_object_pool_move
  import falling_obj_pkg::*;
#(
  parameter int NUM_OBJ   = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int OBJ_W     = 32,
  parameter int SPAWN_Y   = 0,
  parameter int GRAVITY   = 0,
  parameter int VY_MAX    = 512,
  localparam int SLOT_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   freeze,
  input  logic                   spawn_req,
  input  logic signed [10:0]     spawn_x,
  input  logic signed [7:0]      spawn_vx,
  input  logic        [7:0]      spawn_vy,
  output logic                   spawn_ack,
  output logic [SLOT_W-1:0]      spawn_slot,
  input  logic [NUM_OBJ-1:0]     kill,
  output logic [NUM_OBJ-1:0]     active,
  output logic [NUM_OBJ-1:0]     exceed,
  output logic [NUM_OBJ*11-1:0]  topLeftX,
  output logic [NUM_OBJ*11-1:0]  topLeftY
);

  logic                r_ack;
  logic [SLOT_W-1:0]   r_slot;
  logic                w_free_any;
  logic [SLOT_W-1:0]   w_free_idx;
  logic                w_accept;
  logic                w_update;
  logic [NUM_OBJ-1:0]  w_load;

  // Scan downwards so the lowest free index is the last one written.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!active[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  assign w_accept = spawn_req && !r_ack && !startOfFrame && w_free_any;
  assign w_update = startOfFrame && !freeze;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      w_load[i] = w_accept && (w_free_idx == SLOT_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_slot <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_slot <= w_free_idx;
      end
    end
  end

  assign spawn_ack  = r_ack;
  assign spawn_slot = r_slot;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    falling_obj_slot #(
      .FRAC_BITS (FRAC_BITS),
      .X_MAX     (X_MAX),
      .Y_MAX     (Y_MAX),
      .OBJ_W     (OBJ_W),
      .SPAWN_Y   (SPAWN_Y),
      .GRAVITY   (GRAVITY),
      .VY_MAX    (VY_MAX)
    ) u_slot (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_update   (w_update),
      .i_kill     (kill[g]),
      .i_load     (w_load[g]),
      .i_spawn_x  (spawn_x),
      .i_spawn_vx (spawn_vx),
      .i_spawn_vy (spawn_vy),
      .o_active   (active[g]),
      .o_exceed   (exceed[g]),
      .o_px_x     (topLeftX[11*g +: 11]),
      .o_px_y     (topLeftY[11*g +: 11])
    );
  end

endmodule

// File: tb/tb_falling_object_pool_move.sv
// Bench for falling_object_pool_move: two parameterisations driven together, checked
// cycle by cycle against an arithmetic model, plus directed scenario checks.
module tb_falling_object_pool_move;

  localparam int N     = 4;
  localparam int FR    = 64;
  localparam int XLIM  = (639 - 32) * FR;
  localparam int YEXIT = 479 * FR;

  logic               clk = 1'b0;
  logic               reset, sof, freeze, req;
  logic signed [10:0] sx;
  logic signed [7:0]  svx;
  logic        [7:0]  svy;
  logic [N-1:0]       kill;

  logic        ack0, ack1;
  logic [1:0]  slot0, slot1;
  logic [N-1:0] act0, act1, exc0, exc1;
  logic [N*11-1:0] tx0, tx1, ty0, ty1;

  always #5 clk = ~clk;

  falling_object_pool_move u_dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .freeze(freeze), .spawn_req(req),
    .spawn_x(sx), .spawn_vx(svx), .spawn_vy(svy), .spawn_ack(ack0), .spawn_slot(slot0),
    .kill(kill), .active(act0), .exceed(exc0), .topLeftX(tx0), .topLeftY(ty0)
  );

  falling_object_pool_move #(.SPAWN_Y(477), .GRAVITY(16), .VY_MAX(64)) u_dut1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .freeze(freeze), .spawn_req(req),
    .spawn_x(sx), .spawn_vx(svx), .spawn_vy(svy), .spawn_ack(ack1), .spawn_slot(slot1),
    .kill(kill), .active(act1), .exceed(exc1), .topLeftX(tx1), .topLeftY(ty1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state, [dut][slot].
  int m_act[2][N], m_exc[2][N], m_x[2][N], m_y[2][N], m_vx[2][N], m_vy[2][N];
  int m_ack[2], m_slot[2];
  int p_sy[2] = '{0, 477};
  int p_g[2]  = '{0, 16};
  int p_vm[2] = '{512, 64};

  function automatic longint px(input int v);
    int q;
    q = v / FR;
    if (v < 0 && q * FR != v) q = q - 1;
    return longint'(q & 'h7FF);
  endfunction

  task automatic model_edge();
    int lo;
    bit acc;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int s = 0; s < N; s++) begin
          m_act[d][s] = 0; m_exc[d][s] = 0; m_x[d][s] = 0;
          m_y[d][s] = 0; m_vx[d][s] = 0; m_vy[d][s] = 0;
        end
        m_ack[d] = 0;
        m_slot[d] = 0;
        continue;
      end
      lo = -1;
      for (int s = 0; s < N; s++) if (m_act[d][s] == 0 && lo < 0) lo = s;
      for (int s = 0; s < N; s++) begin
        m_exc[d][s] = 0;
        if (m_act[d][s] != 0) begin
          if (kill[s]) m_act[d][s] = 0;
          else if (sof && !freeze) begin
            m_vy[d][s] = m_vy[d][s] + p_g[d];
            if (m_vy[d][s] > p_vm[d]) m_vy[d][s] = p_vm[d];
            m_y[d][s] = m_y[d][s] + m_vy[d][s];
            m_x[d][s] = m_x[d][s] + m_vx[d][s];
            if (m_x[d][s] < 0) begin
              m_x[d][s] = 0; m_vx[d][s] = -m_vx[d][s];
            end else if (m_x[d][s] > XLIM) begin
              m_x[d][s] = XLIM; m_vx[d][s] = -m_vx[d][s];
            end
            if (m_y[d][s] >= YEXIT) begin
              m_act[d][s] = 0; m_exc[d][s] = 1;
            end
          end
        end
      end
      acc = req && m_ack[d] == 0 && !sof && lo >= 0;
      if (acc) begin
        m_act[d][lo] = 1;
        m_x[d][lo]   = int'(sx) * FR;
        m_y[d][lo]   = p_sy[d] * FR;
        m_vx[d][lo]  = int'(svx);
        m_vy[d][lo]  = int'(svy);
        m_slot[d]    = lo;
      end
      m_ack[d] = acc ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    longint e_act, e_exc, e_tx, e_ty;
    for (int d = 0; d < 2; d++) begin
      e_act = 0; e_exc = 0; e_tx = 0; e_ty = 0;
      for (int s = 0; s < N; s++) begin
        e_act |= longint'(m_act[d][s] != 0) << s;
        e_exc |= longint'(m_exc[d][s] != 0) << s;
        e_tx  |= px(m_x[d][s]) << (11 * s);
        e_ty  |= px(m_y[d][s]) << (11 * s);
      end
      check($sformatf("d%0d active", d), longint'(d == 0 ? act0 : act1), e_act);
      check($sformatf("d%0d exceed", d), longint'(d == 0 ? exc0 : exc1), e_exc);
      check($sformatf("d%0d topLeftX", d), longint'(d == 0 ? tx0 : tx1), e_tx);
      check($sformatf("d%0d topLeftY", d), longint'(d == 0 ? ty0 : ty1), e_ty);
      check($sformatf("d%0d ack", d), longint'(d == 0 ? ack0 : ack1), longint'(m_ack[d]));
      if (m_ack[d] != 0)
        check($sformatf("d%0d slot", d), longint'(d == 0 ? slot0 : slot1), longint'(m_slot[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    reset = 1'b0; sof = 1'b0; freeze = 1'b0; req = 1'b0; kill = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic spawn(input int x, input int vx, input int vy);
    req = 1'b1; sx = 11'(x); svx = 8'(vx); svy = 8'(vy);
    step();
    req = 1'b0;
    step();
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    step();
    sof = 1'b0;
  endtask

  initial begin
    idle();
    sx = '0; svx = '0; svy = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset active", longint'(act0), 0);
    check("reset pos", longint'(ty1), 0);

    // Basic fall: slot 0 drops one pixel per frame.
    req = 1'b1; sx = 11'sd100; svx = 8'sd0; svy = 8'd64;
    step();
    req = 1'b0;
    check("t1 ack", longint'(ack0), 1);
    check("t1 slot", longint'(slot0), 0);
    for (int i = 0; i < 5; i++) begin
      sof_pulse();
      if (i == 1) check("t4 exceed pulse", longint'(exc1[0]), 1);
      if (i == 1) check("t4 inactive", longint'(act1[0]), 0);
      step();
      if (i == 1) check("t4 exceed one cycle", longint'(exc1[0]), 0);
    end
    check("t1 Y", longint'(ty0[10:0]), 5);
    check("t1 X", longint'(tx0[10:0]), 100);

    // Fill the pool, hold a fifth request, free slot 2.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req = 1'b1; sx = 11'(200 + 50 * i); svx = '0; svy = '0;
      step();
      req = 1'b0;
      check("t2 fill slot", longint'(slot0), longint'(i));
      step();
    end
    req = 1'b1;
    step();
    step();
    check("t2 full no ack", longint'(ack0), 0);
    kill = 4'b0100;
    step();
    kill = '0;
    check("t2 freed not yet", longint'(ack0), 0);
    step();
    req = 1'b0;
    check("t2 late ack", longint'(ack0), 1);
    check("t2 late slot", longint'(slot0), 2);
    step();

    // Wall bounces on both sides.
    do_reset();
    spawn(1, -128, 0);
    spawn(606, 100, 0);
    sof_pulse();
    check("t3 left clamp", longint'(tx0[10:0]), 0);
    check("t3 right clamp", longint'(tx0[21:11]), 607);
    sof_pulse();
    check("t3 left bounce", longint'(tx0[10:0]), 2);
    check("t3 right bounce", longint'(tx0[21:11]), 605);

    // Kill on the frame a slot would exit: freed, no exceed.
    do_reset();
    spawn(100, 0, 64);
    sof_pulse();
    sof = 1'b1; kill = 4'b0001;
    step();
    sof = 1'b0; kill = '0;
    check("t5 killed", longint'(act1[0]), 0);
    check("t5 no exceed", longint'(exc1[0]), 0);
    step();
    check("t5 no exceed later", longint'(exc1[0]), 0);

    // Gravity saturation and freeze.
    do_reset();
    spawn(50, 3, 0);
    for (int i = 0; i < 3; i++) sof_pulse();
    check("t6 grav Y", longint'(ty1[10:0]), 478);
    freeze = 1'b1;
    sof_pulse();
    freeze = 1'b0;
    check("t6 freeze Y", longint'(ty1[10:0]), 478);
    sof_pulse();
    check("t6 exit", longint'(exc1[0]), 1);

    // Randomised traffic, including occasional mid-motion reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 299) == 0);
      sof    = ($urandom_range(0, 3) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      req    = ($urandom_range(0, 1) == 1);
      for (int s = 0; s < N; s++) kill[s] = ($urandom_range(0, 39) == 0);
      sx  = 11'(int'($urandom_range(0, 720)) - 40);
      svx = 8'($urandom_range(0, 255));
      svy = 8'($urandom_range(0, 255));
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
